// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the CPU pipeline-stage registers:
//   - default payload width and the reset/NOP payload encoding
//   - occupancy state of a two-entry skid buffer and helpers that translate
//     between the state and the per-entry valid bits
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

  // Default payload width (instruction word or PC).
  localparam int unsigned PIPE_DATA_W = 32;

  // Payload loaded on reset; all-zero doubles as the pipeline bubble encoding.
  localparam logic [31:0] PIPE_NOP_WORD = 32'h0000_0000;

  // Occupancy of the skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // neither entry holds data
    BUSY  = 2'b01,  // main entry valid, skid entry empty
    FULL  = 2'b11   // both entries valid
  } pipe_state_e;

  // Decode the stored valid bits into an occupancy state. A skid entry
  // without a main entry cannot occur; it is folded into EMPTY.
  function automatic pipe_state_e valids_to_state(input logic main_v,
                                                  input logic skid_v);
    pipe_state_e st;
    case ({skid_v, main_v})
      2'b01:   st = BUSY;
      2'b11:   st = FULL;
      default: st = EMPTY;
    endcase
    return st;
  endfunction

  // Main entry is occupied in every non-empty state.
  function automatic logic state_main_v(input pipe_state_e st);
    return (st != EMPTY);
  endfunction

  // Skid entry is occupied only when the buffer is full.
  function automatic logic state_skid_v(input pipe_state_e st);
    return (st == FULL);
  endfunction

endpackage : cpu_pipe_pkg

// File: rtl/pipe_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
// W-bit payload register with asynchronous active-high reset and load enable.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-high reset, loads RESET_VAL
//   load_i  in  capture d_i at the next edge when high, otherwise hold
//   d_i     in  W-bit next value
//   q_o     out W-bit stored value
// -----------------------------------------------------------------------------
module pipe_data_reg #(
  parameter int unsigned   W         = 32,
  parameter logic [W-1:0]  RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Payload storage: async clear to RESET_VAL, load-enabled capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry valid/ready pipeline register (skid buffer) between CPU stages.
// Data is forwarded with one cycle of latency; in_ready comes straight from a
// flop so downstream backpressure never reaches upstream combinationally.
// flush squashes both entries at the next edge (data registers keep values).
//
// Ports:
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-high reset, clears all state at once
//   flush      in  synchronous squash, buffer becomes empty at the next edge
//   in_valid   in  upstream offers in_data
//   in_ready   out buffer can accept (registered: !skid_v)
//   in_data    in  DATA_W upstream payload
//   out_valid  out out_data is valid (main_v)
//   out_ready  in  downstream accepts this cycle
//   out_data   out DATA_W payload from the main entry
//   stall_cnt  out 16-bit saturating count of out_valid & !out_ready cycles
//                  (only when PIPE_SKID_PERF_EN is defined)
//
// Build option: PIPE_SKID_PERF_EN adds the stall counter and its port.
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(PIPE_NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              main_load_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              acc_s;
  logic              pop_s;
  pipe_state_e       state_s;
  pipe_state_e       state_d;

  assign state_s = valids_to_state(main_v_q, skid_v_q);
  assign acc_s   = in_valid & ~skid_v_q;
  assign pop_s   = main_v_q & out_ready;

  // Next-state and data-register load decisions.
  always_comb begin
    state_d          = state_s;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      // Squash wins over any accept in the same cycle; payload regs hold.
      state_d = EMPTY;
    end else begin
      case (state_s)
        EMPTY: begin
          if (acc_s) begin
            state_d     = BUSY;
            main_load_s = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        BUSY: begin
          if (acc_s && pop_s) begin
            state_d     = BUSY;
            main_load_s = 1'b1;
          end else if (acc_s) begin
            state_d     = FULL;
            skid_load_s = 1'b1;
          end else if (pop_s) begin
            state_d = EMPTY;
          end else begin
            state_d = BUSY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop_s) begin
            state_d          = BUSY;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign main_v_d = state_main_v(state_d);
  assign skid_v_d = state_skid_v(state_d);
  assign main_d   = main_from_skid_s ? skid_q : in_data;

  // Entry valid bits; the buffer state is decoded from these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  pipe_data_reg #(
    .W         (DATA_W),
    .RESET_VAL (RESET_DATA)
  ) u_main_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_load_s),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_data_reg #(
    .W         (DATA_W),
    .RESET_VAL (RESET_DATA)
  ) u_skid_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load_s),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign in_ready  = ~skid_v_q;

`ifdef PIPE_SKID_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where downstream refuses valid data.
  // Only reset clears it; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else if (main_v_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_skid_reg
